// File: rtl/serializer_pkg.sv
`default_nettype none
// ============================================================================
// Module      : serializer_pkg
// Description : Shared constants and length decode for the serializer.
// Revision    : 1.0 - initial release
// ============================================================================
package serializer_pkg;

    localparam int DATA_W  = 16;
    localparam int MOD_W   = 4;
    localparam int MIN_LEN = 3;

    // A length field of zero encodes a full-width word.
    function automatic int decode_len(input int mod, input int data_w);
        return (mod == 0) ? data_w : mod;
    endfunction

endpackage : serializer_pkg
`default_nettype wire

// File: rtl/serializer.sv
`default_nettype none
// ============================================================================
// Module      : serializer
// Description : Parallel-to-serial transmitter, LSB first, with one pending
//               slot so consecutive words stream without gaps.
// Revision    : 1.0 - initial release
// ============================================================================
module serializer
    import serializer_pkg::*;
#(
    parameter int DATA_W = serializer_pkg::DATA_W,
    parameter int MOD_W  = serializer_pkg::MOD_W
) (
    input  logic              clk_i,
    input  logic              srst_i,
    input  logic [DATA_W-1:0] data_i,
    input  logic [MOD_W-1:0]  data_mod_i,
    input  logic              data_val_i,
    output logic              ready_o,
    output logic              ser_data_o,
    output logic              ser_data_val_o,
    output logic              busy_o
);

    localparam int LEN_W = MOD_W + 1;

    if (MOD_W != $clog2(DATA_W)) begin : g_bad_mod_w
        $error("serializer: MOD_W must equal $clog2(DATA_W)");
    end

    logic [DATA_W-1:0] r_shift;
    logic [LEN_W-1:0]  r_cnt;
    logic [DATA_W-1:0] r_pend_data;
    logic [LEN_W-1:0]  r_pend_len;
    logic              r_pend_val;

    logic [LEN_W-1:0]  w_len;
    logic              w_len_ok;
    logic              w_accept;
    logic              w_load;
    logic              w_active;
    logic              w_last;
    logic              w_free;

    assign w_len    = LEN_W'(decode_len(int'(data_mod_i), DATA_W));
    assign w_len_ok = (data_mod_i == '0) || (data_mod_i >= MOD_W'(MIN_LEN));
    assign w_accept = data_val_i & ~r_pend_val & ~srst_i;
    // Too-short words are accepted but never stored.
    assign w_load   = w_accept & w_len_ok;

    assign w_active = (r_cnt != '0);
    assign w_last   = (r_cnt == LEN_W'(1));
    assign w_free   = ~w_active | w_last;

    always_ff @(posedge clk_i) begin
        if (srst_i) begin
            r_shift     <= '0;
            r_cnt       <= '0;
            r_pend_data <= '0;
            r_pend_len  <= '0;
            r_pend_val  <= 1'b0;
        end else if (w_free) begin
            // Shifter is idle or on its last bit: refill so the next word follows with no gap.
            if (r_pend_val) begin
                r_shift    <= r_pend_data;
                r_cnt      <= r_pend_len;
                r_pend_val <= 1'b0;
            end else if (w_load) begin
                r_shift <= data_i;
                r_cnt   <= w_len;
            end else begin
                r_shift <= '0;
                r_cnt   <= '0;
            end
        end else begin
            r_shift <= r_shift >> 1;
            r_cnt   <= r_cnt - LEN_W'(1);
            if (w_load) begin
                r_pend_data <= data_i;
                r_pend_len  <= w_len;
                r_pend_val  <= 1'b1;
            end
        end
    end

    assign ready_o        = srst_i | ~r_pend_val;
    assign ser_data_val_o = w_active & ~srst_i;
    assign ser_data_o     = r_shift[0] & ser_data_val_o;
    assign busy_o         = ~srst_i & (w_active | r_pend_val);

endmodule : serializer
`default_nettype wire

// File: tb/tb_serializer.sv
`default_nettype none
// ============================================================================
// Module      : tb_serializer
// Description : Randomized self-checking bench for serializer against a
//               queue-of-words reference model plus a loopback word check.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_serializer;

    logic        clk_i = 1'b0;
    logic        srst_i;
    logic [15:0] data_i;
    logic [3:0]  data_mod_i;
    logic        data_val_i;
    logic        ready_o;
    logic        ser_data_o;
    logic        ser_data_val_o;
    logic        busy_o;

    always #5 clk_i = ~clk_i;

    serializer #(.DATA_W(16), .MOD_W(4)) u_dut (
        .clk_i          (clk_i),
        .srst_i         (srst_i),
        .data_i         (data_i),
        .data_mod_i     (data_mod_i),
        .data_val_i     (data_val_i),
        .ready_o        (ready_o),
        .ser_data_o     (ser_data_o),
        .ser_data_val_o (ser_data_val_o),
        .busy_o         (busy_o)
    );

    int n_checks = 0;
    int n_errors = 0;

    // Reference model: words in flight, front one is being shifted.
    int q_data[$];
    int q_len[$];

    int val_cnt  = 0;
    int busy_cnt = 0;
    int n_acc    = 0;

    bit          lb_en = 1'b0;
    int          sent_q[$];
    logic [15:0] lb_sh = '0;
    int          lb_n  = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic cycle(input bit v, input logic [15:0] d, input logic [3:0] m, input bit r);
        bit e_val, e_bit, e_ready, e_busy, acc;
        int len;
        data_val_i = v;
        data_i     = d;
        data_mod_i = m;
        srst_i     = r;
        #1;
        e_val   = !r && (q_len.size() > 0);
        e_bit   = e_val && ((q_data[0] & 1) == 1);
        e_ready = r || (q_len.size() < 2);
        e_busy  = !r && (q_len.size() > 0);
        check("ser_val", 32'(ser_data_val_o), 32'(e_val));
        check("ser_bit", 32'(ser_data_o), 32'(e_bit));
        check("ready", 32'(ready_o), 32'(e_ready));
        check("busy", 32'(busy_o), 32'(e_busy));
        if (ser_data_val_o === 1'b1) val_cnt++;
        if (busy_o === 1'b1) busy_cnt++;
        if (lb_en && ser_data_val_o === 1'b1) begin
            lb_sh = {ser_data_o, lb_sh[15:1]};
            lb_n++;
            if (lb_n == 16) begin
                if (sent_q.size() == 0) check("loopback_extra", 32'(lb_sh), 32'hFFFF_FFFF);
                else check("loopback", 32'(lb_sh), 32'(sent_q.pop_front()));
                lb_n = 0;
            end
        end
        acc = v && e_ready && !r;
        len = (m == 0) ? 16 : int'(m);
        if (acc) n_acc++;
        if (acc && lb_en) sent_q.push_back(int'(d));
        @(posedge clk_i);
        if (r) begin
            q_data.delete();
            q_len.delete();
        end else begin
            if (q_len.size() > 0) begin
                q_data[0] = q_data[0] >> 1;
                q_len[0]  = q_len[0] - 1;
                if (q_len[0] == 0) begin
                    void'(q_data.pop_front());
                    void'(q_len.pop_front());
                end
            end
            if (acc && (m == 0 || m >= 3)) begin
                q_data.push_back(int'(d));
                q_len.push_back(len);
            end
        end
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle(1'b0, 16'($urandom), 4'($urandom), 1'b0);
    endtask

    initial begin
        data_val_i = 1'b0;
        data_i     = '0;
        data_mod_i = '0;
        srst_i     = 1'b1;
        for (int i = 0; i < 3; i++) cycle(1'b1, 16'hFFFF, 4'd0, 1'b1);
        check("rst_ready", 32'(ready_o), 32'd1);

        // Full-width word, LSB first; later input changes must not matter.
        val_cnt = 0;
        cycle(1'b1, 16'hA5C3, 4'd0, 1'b0);
        idle(20);
        check("a5c3_nbits", 32'(val_cnt), 32'd16);

        val_cnt = 0; busy_cnt = 0;
        cycle(1'b1, 16'h00FF, 4'd5, 1'b0);
        idle(10);
        check("mod5_nbits", 32'(val_cnt), 32'd5);
        check("mod5_busy", 32'(busy_cnt), 32'd5);

        val_cnt = 0; busy_cnt = 0;
        cycle(1'b1, 16'hFFFF, 4'd1, 1'b0);
        cycle(1'b1, 16'hFFFF, 4'd2, 1'b0);
        idle(4);
        check("short_nbits", 32'(val_cnt), 32'd0);
        check("short_busy", 32'(busy_cnt), 32'd0);

        // Back-to-back A/B, third word offered while not ready.
        val_cnt = 0;
        cycle(1'b1, 16'h000A, 4'd4, 1'b0);
        cycle(1'b1, 16'h0005, 4'd3, 1'b0);
        cycle(1'b1, 16'hFFFF, 4'd0, 1'b0);
        idle(20);
        check("ab_nbits", 32'(val_cnt), 32'd7);

        // Reset at bit 8 with a pending word queued.
        cycle(1'b1, 16'h5A5A, 4'd0, 1'b0);
        cycle(1'b1, 16'h3C3C, 4'd0, 1'b0);
        idle(6);
        cycle(1'b0, 16'h0, 4'd0, 1'b1);
        val_cnt = 0;
        idle(30);
        check("rst_abort_nbits", 32'(val_cnt), 32'd0);

        // Randomized mix including short words and occasional resets.
        for (int i = 0; i < 3000; i++)
            cycle(1'($urandom), 16'($urandom), 4'($urandom), ($urandom_range(0, 99) == 0));
        idle(40);

        // Loopback stream of full-width words offered every cycle.
        lb_en = 1'b1;
        n_acc = 0;
        for (int i = 0; i < 40000 && n_acc < 1000; i++)
            cycle(1'b1, 16'($urandom), 4'd0, 1'b0);
        check("lb_accepted", 32'(n_acc), 32'd1000);
        idle(40);
        check("lb_drained", 32'(sent_q.size()), 32'd0);
        check("lb_partial", 32'(lb_n), 32'd0);
        lb_en = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule : tb_serializer
`default_nettype wire

// File: doc/serializer.md
SERIALIZER -- requirements
Module: serializer

Interface
REQ-001 Parameter DATA_W, default 16, parallel word width.
REQ-002 Parameter MOD_W, default 4, length-field width; must equal $clog2(DATA_W).
REQ-003 clk_i  input  1  single clock; all logic on posedge.
REQ-004 srst_i  input  1  reset, synchronous, active-high.
REQ-005 data_i  input  DATA_W  parallel word to transmit.
REQ-006 data_mod_i  input  MOD_W  number of valid bits in data_i; 0 means DATA_W.
REQ-007 data_val_i  input  1  data_i/data_mod_i valid this cycle.
REQ-008 ready_o  output  1  block can accept a word this cycle.
REQ-009 ser_data_o  output  1  serial bit, LSB first.
REQ-010 ser_data_val_o  output  1  ser_data_o carries a valid bit.
REQ-011 busy_o  output  1  a word is being shifted or is pending.

Function
REQ-012 A word SHALL be accepted only on a cycle with data_val_i=1 and ready_o=1; data_val_i while ready_o=0 SHALL be ignored with no state change.
REQ-013 Transmit length SHALL be data_mod_i for values 3..15 and DATA_W for 0; bits sent are data_i[0] .. data_i[len-1], in that order, one per cycle.
REQ-014 A word with data_mod_i of 1 or 2 SHALL be accepted and dropped: no serial output, no effect on busy_o or ready_o.
REQ-015 Storage: one shift register (active word) plus one pending slot.
REQ-016 ready_o SHALL equal NOT pending_valid (combinational from registered state).
REQ-017 Accept while shifter idle: word loads into shifter; first bit on ser_data_o with ser_data_val_o=1 in the next cycle (latency 1).
REQ-018 Accept while shifter active: word loads into pending slot; ready_o drops next cycle.
REQ-019 Last bit of active word with pending_valid=1: pending moves to shifter; its first bit appears in the cycle immediately after the last bit (no gap); ready_o rises next cycle.
REQ-020 Last bit of active word with pending empty and a simultaneous accept: accepted word goes straight to shifter, no gap.
REQ-021 ser_data_val_o SHALL be 0 whenever no bit is being driven; ser_data_o SHALL be 0 when ser_data_val_o=0.
REQ-022 Bit counter SHALL be MOD_W+1 bits wide so DATA_W is representable; no wrap-around.
REQ-023 busy_o SHALL be 1 from the cycle after an accept of a transmitting word until the cycle after its last bit, and while pending_valid=1.
REQ-024 data_i/data_mod_i SHALL be sampled only at accept; later changes have no effect on a word in flight.

Reset
REQ-025 While srst_i=1: ser_data_o=0, ser_data_val_o=0, busy_o=0, pending_valid=0, ready_o=1, counter=0, shift register=0.
REQ-026 Reset mid-word SHALL abort active and pending words; no remaining bits are sent; accepts resume the cycle after srst_i deasserts.
REQ-027 A data_val_i concurrent with srst_i=1 SHALL be discarded.

Structure
REQ-028 Package serializer_pkg holds DATA_W, MOD_W, MIN_LEN=3 and the length-decode function (0 -> DATA_W).
REQ-029 Flat module, no sub-module; the block is the transmit counterpart of deserializer and must interoperate with it bit-for-bit (LSB first).

Verification
REQ-030 data_i=16'hA5C3, mod=0, idle -> 16 bits 1,1,0,0,0,0,1,1,1,0,1,0,0,1,0,1 on cycles 1..16, val=1 exactly 16 cycles.
REQ-031 data_i=16'h00FF, mod=5 -> bits 1,1,1,1,1 then val=0; busy_o high 5 cycles.
REQ-032 mod=1 and mod=2 words -> no val pulse, busy_o stays 0, ready_o stays 1.
REQ-033 Word A (mod=4) then B (mod=3) offered on consecutive cycles -> 7 contiguous valid bits, ready_o low from cycle 2 until B enters shifter; third word offered while ready_o=0 never appears.
REQ-034 srst_i pulsed at bit 8 of a 16-bit word with pending word queued -> val=0 next cycle, busy_o=0, ready_o=1, neither word resumes.
REQ-035 Loopback into deserializer with 1000 random mod=0 words back-to-back -> every deser_data_o equals the sent data_i.
